// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// dmem_arb_pkg: shared tags, access types and the read-tag record for dmem_arbiter.
// Revision: 1.0
// ============================================================================
package dmem_arb_pkg;

  localparam logic PORT0     = 1'b0;
  localparam logic PORT1     = 1'b1;
  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_tagpipe.sv
`default_nettype none
// ============================================================================
// dmem_arb_tagpipe: DEPTH-stage {valid, port} shift register, cleared by rst.
// Revision: 1.0
// ============================================================================
module dmem_arb_tagpipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign tag_out = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter: round-robin sharing of one data SRAM between core and debug ports.
// Optional DMEM_ARB_PERF_EN adds saturating grant and conflict counters.
// Revision: 1.0
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data2Mem,
  input  logic [DATA_W-1:0] ReadDataMem
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       p0_gnt_cnt,
  output logic [15:0]       p1_gnt_cnt,
  output logic [15:0]       conflict_cnt
`endif
);

  logic              r_last_gnt;
  logic [ADDR_W-1:0] r_a_hold;
  logic [DATA_W-1:0] r_d_hold;

  logic              w_p0_win;
  logic              w_p1_win;
  logic              w_gnt;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  tag_t              w_tag_in;
  tag_t              w_tag_out;

  // On contention the port that did not win last time goes first.
  always_comb begin
    w_p0_win = !rst && p0_req && (!p1_req || (r_last_gnt == PORT1));
    w_p1_win = !rst && p1_req && (!p0_req || (r_last_gnt == PORT0));
    w_gnt    = w_p0_win || w_p1_win;
    w_we     = w_p1_win ? p1_we    : p0_we;
    w_addr   = w_p1_win ? p1_addr  : p0_addr;
    w_wdata  = w_p1_win ? p1_wdata : p0_wdata;
  end

  assign p0_gnt   = w_p0_win;
  assign p1_gnt   = w_p1_win;
  assign CEN      = !w_gnt;
  assign WEN      = !(w_gnt && (w_we == ACC_WRITE));
  assign OEN      = !(w_gnt && (w_we == ACC_READ));
  assign A        = rst ? '0 : (w_gnt ? w_addr  : r_a_hold);
  assign Data2Mem = rst ? '0 : (w_gnt ? w_wdata : r_d_hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= PORT1;
      r_a_hold   <= '0;
      r_d_hold   <= '0;
    end else if (w_gnt) begin
      r_last_gnt <= w_p1_win ? PORT1 : PORT0;
      r_a_hold   <= w_addr;
      r_d_hold   <= w_wdata;
    end
  end

  assign w_tag_in.valid = w_gnt && (w_we == ACC_READ);
  assign w_tag_in.port  = w_p1_win ? PORT1 : PORT0;

  dmem_arb_tagpipe #(
    .DEPTH (READ_LAT)
  ) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (w_tag_in),
    .tag_out (w_tag_out)
  );

  // The tag that left the pipe steers this cycle's SRAM read data.
  assign p0_rvalid = !rst && w_tag_out.valid && (w_tag_out.port == PORT0);
  assign p1_rvalid = !rst && w_tag_out.valid && (w_tag_out.port == PORT1);
  assign p0_rdata  = p0_rvalid ? ReadDataMem : '0;
  assign p1_rdata  = p1_rvalid ? ReadDataMem : '0;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_gnt_cnt   <= '0;
      p1_gnt_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (w_p0_win)          p0_gnt_cnt   <= sat_inc16(p0_gnt_cnt);
      if (w_p1_win)          p1_gnt_cnt   <= sat_inc16(p1_gnt_cnt);
      if (p0_req && p1_req)  conflict_cnt <= sat_inc16(conflict_cnt);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter: directed vector bench for dmem_arbiter with a READ_LAT=2 SRAM model.
// Revision: 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          CEN, WEN, OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] Data2Mem, ReadDataMem;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0]   p0_gnt_cnt, p1_gnt_cnt, conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .READ_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req       (p0_req),
    .p0_we        (p0_we),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_gnt       (p0_gnt),
    .p0_rvalid    (p0_rvalid),
    .p0_rdata     (p0_rdata),
    .p1_req       (p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_gnt       (p1_gnt),
    .p1_rvalid    (p1_rvalid),
    .p1_rdata     (p1_rdata),
    .CEN          (CEN),
    .WEN          (WEN),
    .OEN          (OEN),
    .A            (A),
    .Data2Mem     (Data2Mem),
    .ReadDataMem  (ReadDataMem)
`ifdef DMEM_ARB_PERF_EN
    ,
    .p0_gnt_cnt   (p0_gnt_cnt),
    .p1_gnt_cnt   (p1_gnt_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // SRAM model: write on the access edge, read data valid LAT cycles after the access.
  logic [DW-1:0] mem     [128];
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (!CEN && !WEN) mem[A] <= Data2Mem;
    rd_pipe[0] <= mem[A];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ReadDataMem = rd_pipe[LAT-1];

  typedef struct {
    logic          rs;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, cen, wen, oen;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          v0;
    logic [DW-1:0] rd0;
    logic          v1;
    logic [DW-1:0] rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic rs,
    input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic g0, input logic g1, input logic cen, input logic wen, input logic oen,
    input logic [AW-1:0] ea, input logic [DW-1:0] ed,
    input logic v0, input logic [DW-1:0] rd0, input logic v1, input logic [DW-1:0] rd1);
    vec_t v;
    v.rs = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.cen = cen; v.wen = wen; v.oen = oen;
    v.ea = ea; v.ed = ed; v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    rst = v.rs;
    p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
    #4;
    chk({tag, " p0_gnt"},    {31'b0, p0_gnt},    {31'b0, v.g0});
    chk({tag, " p1_gnt"},    {31'b0, p1_gnt},    {31'b0, v.g1});
    chk({tag, " CEN"},       {31'b0, CEN},       {31'b0, v.cen});
    chk({tag, " WEN"},       {31'b0, WEN},       {31'b0, v.wen});
    chk({tag, " OEN"},       {31'b0, OEN},       {31'b0, v.oen});
    chk({tag, " A"},         {25'b0, A},         {25'b0, v.ea});
    chk({tag, " Data2Mem"},  Data2Mem,           v.ed);
    chk({tag, " p0_rvalid"}, {31'b0, p0_rvalid}, {31'b0, v.v0});
    chk({tag, " p0_rdata"},  p0_rdata,           v.rd0);
    chk({tag, " p1_rvalid"}, {31'b0, p1_rvalid}, {31'b0, v.v1});
    chk({tag, " p1_rdata"},  p1_rdata,           v.rd1);
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] DB = 32'hDEADBEEF;
  localparam logic [DW-1:0] X1 = 32'h11111111;
  localparam logic [DW-1:0] X2 = 32'h22222222;

  vec_t main_tbl [21];
  vec_t rst_tbl  [9];

  initial begin
    // rs | p0 req we addr wdata | p1 req we addr wdata | g0 g1 cen wen oen | A D2M | p0 rv rd | p1 rv rd
    main_tbl[0]  = mk(0, 1,1,7'h05,DB, 0,0,7'h00,0,  1,0, 0,0,1, 7'h05,DB, 0,0,  0,0);
    main_tbl[1]  = mk(0, 1,0,7'h05,0,  0,0,7'h00,0,  1,0, 0,1,0, 7'h05,0,  0,0,  0,0);
    main_tbl[2]  = mk(0, 0,0,7'h00,0,  0,0,7'h00,0,  0,0, 1,1,1, 7'h05,0,  0,0,  0,0);
    main_tbl[3]  = mk(0, 0,0,7'h00,0,  1,1,7'h10,X1, 0,1, 0,0,1, 7'h10,X1, 1,DB, 0,0);
    main_tbl[4]  = mk(0, 0,0,7'h00,0,  1,1,7'h11,X2, 0,1, 0,0,1, 7'h11,X2, 0,0,  0,0);
    main_tbl[5]  = mk(0, 1,0,7'h10,0,  1,0,7'h11,0,  1,0, 0,1,0, 7'h10,0,  0,0,  0,0);
    main_tbl[6]  = mk(0, 1,0,7'h11,0,  1,0,7'h11,0,  0,1, 0,1,0, 7'h11,0,  0,0,  0,0);
    main_tbl[7]  = mk(0, 1,0,7'h11,0,  1,0,7'h10,0,  1,0, 0,1,0, 7'h11,0,  1,X1, 0,0);
    main_tbl[8]  = mk(0, 1,0,7'h05,0,  1,0,7'h10,0,  0,1, 0,1,0, 7'h10,0,  0,0,  1,X2);
    main_tbl[9]  = mk(0, 1,0,7'h05,0,  1,0,7'h11,0,  1,0, 0,1,0, 7'h05,0,  1,X2, 0,0);
    main_tbl[10] = mk(0, 0,0,7'h00,0,  1,0,7'h11,0,  0,1, 0,1,0, 7'h11,0,  0,0,  1,X1);
    main_tbl[11] = mk(0, 0,0,7'h00,0,  0,0,7'h00,0,  0,0, 1,1,1, 7'h11,0,  1,DB, 0,0);
    main_tbl[12] = mk(0, 0,0,7'h00,0,  0,0,7'h00,0,  0,0, 1,1,1, 7'h11,0,  0,0,  1,X2);
    main_tbl[13] = mk(0, 0,0,7'h00,0,  1,0,7'h05,0,  0,1, 0,1,0, 7'h05,0,  0,0,  0,0);
    main_tbl[14] = mk(0, 0,0,7'h00,0,  1,0,7'h05,0,  0,1, 0,1,0, 7'h05,0,  0,0,  0,0);
    main_tbl[15] = mk(0, 0,0,7'h00,0,  1,0,7'h05,0,  0,1, 0,1,0, 7'h05,0,  0,0,  1,DB);
    main_tbl[16] = mk(0, 0,0,7'h00,0,  1,0,7'h05,0,  0,1, 0,1,0, 7'h05,0,  0,0,  1,DB);
    main_tbl[17] = mk(0, 1,0,7'h10,0,  1,0,7'h11,0,  1,0, 0,1,0, 7'h10,0,  0,0,  1,DB);
    main_tbl[18] = mk(0, 0,0,7'h00,0,  1,0,7'h11,0,  0,1, 0,1,0, 7'h11,0,  0,0,  1,DB);
    main_tbl[19] = mk(0, 0,0,7'h00,0,  0,0,7'h00,0,  0,0, 1,1,1, 7'h11,0,  1,X1, 0,0);
    main_tbl[20] = mk(0, 0,0,7'h00,0,  0,0,7'h00,0,  0,0, 1,1,1, 7'h11,0,  0,0,  1,X2);

    // Two reads in flight, one-cycle reset, then contention and fresh reads.
    rst_tbl[0] = mk(0, 1,0,7'h05,0, 0,0,7'h00,0, 1,0, 0,1,0, 7'h05,0, 0,0,  0,0);
    rst_tbl[1] = mk(0, 0,0,7'h00,0, 1,0,7'h10,0, 0,1, 0,1,0, 7'h10,0, 0,0,  0,0);
    rst_tbl[2] = mk(1, 1,0,7'h11,0, 1,0,7'h11,0, 0,0, 1,1,1, 7'h00,0, 0,0,  0,0);
    rst_tbl[3] = mk(0, 1,0,7'h05,0, 1,0,7'h10,0, 1,0, 0,1,0, 7'h05,0, 0,0,  0,0);
    rst_tbl[4] = mk(0, 0,0,7'h00,0, 1,0,7'h10,0, 0,1, 0,1,0, 7'h10,0, 0,0,  0,0);
    rst_tbl[5] = mk(0, 0,0,7'h00,0, 0,0,7'h00,0, 0,0, 1,1,1, 7'h10,0, 1,DB, 0,0);
    rst_tbl[6] = mk(0, 0,0,7'h00,0, 0,0,7'h00,0, 0,0, 1,1,1, 7'h10,0, 0,0,  1,X1);
    rst_tbl[7] = mk(0, 0,1,7'h05,0, 1,1,7'h05,X2,0,1, 0,0,1, 7'h05,X2,0,0,  0,0);
    rst_tbl[8] = mk(0, 1,0,7'h05,0, 0,0,7'h00,0, 1,0, 0,1,0, 7'h05,0, 0,0,  0,0);

    // Reset held two cycles with both ports requesting: nothing may be granted.
    apply(mk(1, 1,0,7'h05,0, 1,1,7'h11,X1, 0,0, 1,1,1, 7'h00,0, 0,0, 0,0), "reset0");
    apply(mk(1, 1,0,7'h05,0, 1,1,7'h11,X1, 0,0, 1,1,1, 7'h00,0, 0,0, 0,0), "reset1");

    for (int i = 0; i < 21; i++) apply(main_tbl[i], $sformatf("main%0d", i));
    for (int i = 0; i < 9; i++)  apply(rst_tbl[i],  $sformatf("rstseq%0d", i));
    // Read-after-write in the next cycle returns the new data.
    apply(mk(0, 0,0,7'h00,0, 0,0,7'h00,0, 0,0, 1,1,1, 7'h05,0, 0,0, 0,0), "raw_wait");
    apply(mk(0, 0,0,7'h00,0, 0,0,7'h00,0, 0,0, 1,1,1, 7'h05,0, 1,X2, 0,0), "raw_resp");

`ifdef DMEM_ARB_PERF_EN
    apply(mk(1, 0,0,7'h00,0, 0,0,7'h00,0, 0,0, 1,1,1, 7'h00,0, 0,0, 0,0), "perf_rst");
    for (int k = 0; k < 10; k++) begin
      rst = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 7'(k); p0_wdata = '0;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 7'(k + 32); p1_wdata = '0;
      #4;
      chk($sformatf("perf%0d p0_gnt", k), {31'b0, p0_gnt}, {31'b0, (k % 2) == 0});
      chk($sformatf("perf%0d p1_gnt", k), {31'b0, p1_gnt}, {31'b0, (k % 2) == 1});
      @(posedge clk);
      #1;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    #4;
    chk("conflict_cnt", {16'b0, conflict_cnt}, 32'd10);
    chk("p0_gnt_cnt",   {16'b0, p0_gnt_cnt},   32'd5);
    chk("p1_gnt_cnt",   {16'b0, p1_gnt_cnt},   32'd5);
    @(posedge clk);
    #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
